inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
- REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; power of two, minimum 2.
- REQ-002 SHALL have parameter XLEN, default 32, width of PC and instruction words.
- REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
- REQ-005 SHALL have port flush, input, 1, discards all queued entries (redirect or mispredict).
- REQ-006 SHALL have port in_valid, input, 1, fetch presents an instruction.
- REQ-007 SHALL have port in_ready, output, 1, queue can accept an instruction.
- REQ-008 SHALL have port in_pc, input, XLEN, PC of the incoming instruction.
- REQ-009 SHALL have port in_instruction, input, XLEN, raw 32-bit RISC-V instruction word.
- REQ-010 SHALL have port out_valid, output, 1, head entry is available to decode.
- REQ-011 SHALL have port out_ready, input, 1, decode consumes the head entry.
- REQ-012 SHALL have port out_pc, output, XLEN, PC of the head entry.
- REQ-013 SHALL have port out_instruction, output, XLEN, head instruction, fed unchanged to the decode format splitters.
- REQ-014 SHALL have port count, output, $clog2(DEPTH)+1, number of occupied entries.

Function
- REQ-015 SHALL push on a cycle with in_valid && in_ready && !flush: write {in_pc, in_instruction} at the tail, then advance the tail.
- REQ-016 SHALL pop on a cycle with out_valid && out_ready && !flush: advance the head.
- REQ-017 SHALL drive in_ready = (count < DEPTH), independent of out_ready, so there is no combinational ready path.
- REQ-018 SHALL drive out_valid = (count != 0), except as modified by REQ-027.
- REQ-019 SHALL drive out_pc and out_instruction from the head entry when out_valid, and all-zero when not valid.
- REQ-020 SHALL leave count unchanged on a simultaneous push and pop, including when count == 1.
- REQ-021 SHALL wrap head and tail modulo DEPTH; preserve FIFO order across wrap.
- REQ-022 SHALL give flush priority over push and pop: next cycle, count = 0 and head = tail = 0; a same-cycle push is dropped.
- REQ-023 SHALL have a minimum latency of 1 cycle from push to out_valid, unless the bypass is compiled in.
- REQ-024 SHALL hold head outputs stable while out_valid && !out_ready (no retraction and no data change).

Reset
- REQ-025 SHALL make rst take priority over flush and the handshakes: count = 0, head = tail = 0, out_valid = 0, in_ready = 1, out_pc = out_instruction = 0.
- REQ-026 SHALL discard in-flight entries when rst is asserted mid-stream; storage contents need not be cleared.

Configuration
- REQ-027 SHALL, with INST_QUEUE_BYPASS_EN defined and count == 0 and in_valid: assert out_valid combinationally with out_pc/out_instruction = in_pc/in_instruction; if out_ready is also high, the entry is consumed and is not written.
- REQ-028 SHALL, with INST_QUEUE_BYPASS_EN undefined, have no input-to-output combinational path, per REQ-023.

Structure
- REQ-029 SHALL place the entry struct {pc, instruction}, XLEN and the default DEPTH in a shared package decode_pkg.
- REQ-030 SHALL use one sub-module, inst_queue_ram: DEPTH x (2*XLEN), one write port and one asynchronous read port, no reset.

Verification
- REQ-031 SHALL cover fill then drain: 4 pushes (pc 0x0, 0x4, 0x8, 0xC) with out_ready=0 -> count=4, in_ready=0; then out_ready=1 -> pops in order 0x0..0xC, count reaches 0.
- REQ-032 SHALL cover simultaneous push and pop with count=2 for 10 cycles -> count stays 2, FIFO order intact across pointer wrap.
- REQ-033 SHALL cover flush with count=3 and in_valid=1 the same cycle -> next cycle count=0, out_valid=0, flushed instruction never appears.
- REQ-034 SHALL cover bypass: count=0, in_valid=1 (instr 0x00A12023, sw), out_ready=1 -> same cycle out_instruction=0x00A12023 with bypass, else appears next cycle.
- REQ-035 SHALL cover rst with count=2 mid-stream -> next cycle count=0, in_ready=1, out_valid=0, outputs zero.
- REQ-036 SHALL cover backpressure: out_valid=1, out_ready=0 for 5 cycles -> out_pc and out_instruction unchanged throughout.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared front-end types and defaults for the instruction queue
// and the decode stage that consumes it.
package decode_pkg;

    // Default machine word width for PC and instruction words.
    localparam int XLEN = 32;

    // Default number of instruction queue entries.
    localparam int DEFAULT_DEPTH = 4;

    // One queued fetch packet, as stored in the queue RAM (pc in the upper half).
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
    } iq_entry_t;

    // Pointer width for a queue of the given depth (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// inst_queue_ram: entry storage for the instruction queue. One write port and
// one asynchronous read port; contents are not reset.
module inst_queue_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the tail entry on a push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// inst_queue: fetch-to-decode instruction FIFO holding {pc, instruction}.
// Optional feature: define INST_QUEUE_BYPASS_EN to let an instruction arriving
// at an empty queue appear on the output in the same cycle (and skip storage
// when decode takes it immediately). Without it the queue has no
// input-to-output combinational path.
module inst_queue #(
    parameter int DEPTH = decode_pkg::DEFAULT_DEPTH,
    parameter int XLEN  = decode_pkg::XLEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [XLEN-1:0]        in_instruction,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_instruction,
    output logic [$clog2(DEPTH):0] count
);
    import decode_pkg::*;

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [CW-1:0]     occ;
    logic [2*XLEN-1:0] rd_data;
    logic [XLEN-1:0]   head_pc;
    logic [XLEN-1:0]   head_ins;
    logic              empty;
    logic              bypass_vld;
    logic              bypass_take;
    logic              push;
    logic              pop;

    assign empty    = (occ == '0);
    assign in_ready = (occ < FULL);
    assign count    = occ;
    assign {head_pc, head_ins} = rd_data;

`ifdef INST_QUEUE_BYPASS_EN
    assign bypass_vld = empty && in_valid;
`else
    assign bypass_vld = 1'b0;
`endif

    // A bypassed instruction taken by decode this cycle never enters storage.
    assign bypass_take = bypass_vld && out_ready && !flush;
    assign push        = in_valid && in_ready && !flush && !bypass_take;
    assign pop         = !empty && out_ready && !flush;

    // Head presentation: stored head first, bypassed input when empty, else zeros.
    always_comb begin
        out_valid       = 1'b0;
        out_pc          = '0;
        out_instruction = '0;
        if (!empty) begin
            out_valid       = 1'b1;
            out_pc          = head_pc;
            out_instruction = head_ins;
        end else if (bypass_vld) begin
            out_valid       = 1'b1;
            out_pc          = in_pc;
            out_instruction = in_instruction;
        end
    end

    // Pointer and occupancy update; reset beats flush, flush beats handshakes.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            occ <= occ + CW'(push) - CW'(pop);
        end
    end

    inst_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (tail),
        .wdata ({in_pc, in_instruction}),
        .raddr (head),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: self-checking bench for inst_queue (default DEPTH=4, XLEN=32).
// Honors INST_QUEUE_BYPASS_EN for the expected same-cycle behaviour.
module tb_inst_queue;

    localparam int DEPTH = 4;
`ifdef INST_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instruction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic [2:0]  count;

    inst_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_instruction  (in_instruction),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic [2:0]  cnt;
        logic        ir;
        logic        ov;
        logic [31:0] opc;
    } vec_t;

    ent_t q[$];
    vec_t tbl[10];
    int   checks = 0;
    int   errors = 0;

    logic [2:0]  s_count;
    logic        s_ir;
    logic        s_ov;
    logic [31:0] s_pc;
    logic [31:0] s_ins;

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return {16'h1234, pc[15:0]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the scoreboard, update it.
    task automatic cycle(input logic r, input logic f, input logic iv,
                         input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy);
        ent_t e;
        int   sz;
        logic byp;
        logic exp_ov;
        rst = r; flush = f; in_valid = iv; in_pc = pc;
        in_instruction = ins; out_ready = ordy;
        @(negedge clk);
        s_count = count; s_ir = in_ready; s_ov = out_valid;
        s_pc = out_pc; s_ins = out_instruction;
        sz = q.size();
        byp = BYP && (sz == 0) && iv;
        exp_ov = (sz != 0) || byp;
        if (sz != 0) e = q[0];
        else if (byp) e = '{pc, ins};
        else e = '{32'h0, 32'h0};
        chk("count", 32'(s_count), 32'(sz));
        chk("in_ready", 32'(s_ir), 32'(sz < DEPTH));
        chk("out_valid", 32'(s_ov), 32'(exp_ov));
        chk("out_pc", s_pc, e.pc);
        chk("out_instruction", s_ins, e.ins);
        if (r || f) begin
            q.delete();
        end else begin
            if (exp_ov && ordy && !byp) void'(q.pop_front());
            if (iv && (sz < DEPTH) && !(byp && ordy)) q.push_back('{pc, ins});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // fill then drain table: {iv, pc, out_ready, count, in_ready, out_valid, out_pc}
        tbl[0] = '{1'b1, 32'h0, 1'b0, 3'd0, 1'b1, BYP,  32'h0};
        tbl[1] = '{1'b1, 32'h4, 1'b0, 3'd1, 1'b1, 1'b1, 32'h0};
        tbl[2] = '{1'b1, 32'h8, 1'b0, 3'd2, 1'b1, 1'b1, 32'h0};
        tbl[3] = '{1'b1, 32'hC, 1'b0, 3'd3, 1'b1, 1'b1, 32'h0};
        tbl[4] = '{1'b0, 32'h0, 1'b0, 3'd4, 1'b0, 1'b1, 32'h0};
        tbl[5] = '{1'b0, 32'h0, 1'b1, 3'd4, 1'b0, 1'b1, 32'h0};
        tbl[6] = '{1'b0, 32'h0, 1'b1, 3'd3, 1'b1, 1'b1, 32'h4};
        tbl[7] = '{1'b0, 32'h0, 1'b1, 3'd2, 1'b1, 1'b1, 32'h8};
        tbl[8] = '{1'b0, 32'h0, 1'b1, 3'd1, 1'b1, 1'b1, 32'hC};
        tbl[9] = '{1'b0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0;
        in_instruction = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("reset_count", 32'(s_count), 32'd0);
        chk("reset_in_ready", 32'(s_ir), 32'd1);
        chk("reset_out_valid", 32'(s_ov), 32'd0);

        // fill then drain
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, tbl[i].iv, tbl[i].pc, ins_of(tbl[i].pc), tbl[i].ordy);
            chk($sformatf("tbl%0d_count", i), 32'(s_count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_in_ready", i), 32'(s_ir), 32'(tbl[i].ir));
            chk($sformatf("tbl%0d_out_valid", i), 32'(s_ov), 32'(tbl[i].ov));
            if (tbl[i].ov) chk($sformatf("tbl%0d_out_pc", i), s_pc, tbl[i].opc);
        end

        // simultaneous push and pop at count 2, wrapping the pointers
        cycle(1'b0, 1'b0, 1'b1, 32'h100, ins_of(32'h100), 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h104, ins_of(32'h104), 1'b0);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h108 + 32'(4*k), ins_of(32'h108 + 32'(4*k)), 1'b1);
            chk("simul_count", 32'(s_count), 32'd2);
            chk("simul_head", s_pc, 32'h100 + 32'(4*k));
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("simul_drained", 32'(s_count), 32'd0);

        // flush with count 3 and a same-cycle push
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h200 + 32'(4*k), ins_of(32'h200 + 32'(4*k)), 1'b0);
        end
        cycle(1'b0, 1'b1, 1'b1, 32'hDEAD, 32'hDEADBEEF, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("flush_count", 32'(s_count), 32'd0);
        chk("flush_out_valid", 32'(s_ov), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'h300, ins_of(32'h300), 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("flush_next_head", s_ins, ins_of(32'h300));
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // bypass (or one-cycle latency) with a sw instruction
        cycle(1'b0, 1'b0, 1'b1, 32'h400, 32'h00A12023, 1'b1);
        chk("byp_same_cycle", s_ins, BYP ? 32'h00A12023 : 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("byp_next_cycle", s_ins, BYP ? 32'h0 : 32'h00A12023);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // reset mid-stream with count 2
        cycle(1'b0, 1'b0, 1'b1, 32'h600, ins_of(32'h600), 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h604, ins_of(32'h604), 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("rst_count", 32'(s_count), 32'd0);
        chk("rst_in_ready", 32'(s_ir), 32'd1);
        chk("rst_out_valid", 32'(s_ov), 32'd0);
        chk("rst_out_pc", s_pc, 32'h0);
        chk("rst_out_instruction", s_ins, 32'h0);

        // backpressure holds the head stable
        cycle(1'b0, 1'b0, 1'b1, 32'h500, ins_of(32'h500), 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            chk("bp_out_pc", s_pc, 32'h500);
            chk("bp_out_instruction", s_ins, ins_of(32'h500));
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("bp_drained", 32'(s_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
